// File: rtl/cbus_arbiter.sv
// Cbus request/response types and an N-way arbiter that grants one cache at a time
// to the shared memory bus and holds the grant for a whole burst.
package cbus_pkg;
  localparam logic [1:0] MLEN1  = 2'd0;
  localparam logic [1:0] MLEN4  = 2'd1;
  localparam logic [1:0] MLEN8  = 2'd2;
  localparam logic [1:0] MLEN16 = 2'd3;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [1:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_INPUTS],
  output cbus_resp_t iresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int          IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned NI = NUM_INPUTS;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    r_state;
  logic [IW-1:0] r_sel_idx;
  logic [IW-1:0] r_rr_ptr;

  logic [IW-1:0] w_winner;
  logic [IW-1:0] w_cand;
  logic          w_any;
  logic          w_sel_valid;
  logic [IW-1:0] w_rr_next;

  // Scan starts at rr_ptr for rotating priority, at index 0 for fixed priority.
  always_comb begin
    w_winner = '0;
    w_any    = 1'b0;
    w_cand   = '0;
    for (int unsigned k = 0; k < NI; k++) begin
      if (ROUND_ROBIN != 0) begin
        w_cand = IW'((32'(r_rr_ptr) + k) % NI);
      end else begin
        w_cand = IW'(k);
      end
      if (!w_any && ireqs[w_cand].valid) begin
        w_any    = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_sel_valid = ireqs[r_sel_idx].valid;
  assign w_rr_next   = (32'(r_sel_idx) == NI - 1) ? '0 : r_sel_idx + 1'b1;

  // Outputs depend only on state and requests, never on oresp toward oreq.
  always_comb begin
    oreq = '0;
    for (int unsigned i = 0; i < NI; i++) begin
      iresps[i] = '0;
      if (r_state == S_BUSY && IW'(i) == r_sel_idx) begin
        iresps[i] = oresp;
      end
    end
    if (r_state == S_BUSY) begin
      oreq = ireqs[r_sel_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sel_idx <= '0;
      r_rr_ptr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel_idx <= w_winner;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          // An abort releases the bus without advancing the rotation.
          if (!w_sel_valid) begin
            r_state <= S_IDLE;
          end else if (oresp.ready && oresp.last) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= w_rr_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: one rotating-priority and one fixed-priority instance.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  cbus_req_t  ireqs    [2];
  cbus_resp_t iresps   [2];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  cbus_req_t  ireqs_f  [2];
  cbus_resp_t iresps_f [2];
  cbus_req_t  oreq_f;
  cbus_resp_t oresp_f;

  int n_cmp = 0;
  int n_err = 0;

  cbus_arbiter #(.NUM_INPUTS(2), .ROUND_ROBIN(1)) dut (
    .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps), .oreq(oreq), .oresp(oresp)
  );

  cbus_arbiter #(.NUM_INPUTS(2), .ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .reset(reset), .ireqs(ireqs_f), .iresps(iresps_f), .oreq(oreq_f), .oresp(oresp_f)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cbus_req_t mkreq(input logic wr, input logic [31:0] addr,
                                      input logic [1:0] len, input logic [7:0] strobe,
                                      input logic [63:0] data);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.size     = wr ? 3'd2 : 3'd3;
    r.addr     = addr;
    r.strobe   = strobe;
    r.data     = data;
    r.len      = len;
    r.burst    = (len == MLEN1) ? 2'd0 : 2'd1;
    return r;
  endfunction

  function automatic cbus_resp_t mkresp(input logic rdy, input logic lst, input logic [63:0] d);
    cbus_resp_t r;
    r.ready = rdy;
    r.last  = lst;
    r.data  = d;
    return r;
  endfunction

  // Drives n ready beats toward requester idx, checking mirroring and forwarding each beat.
  task automatic run_burst(input logic idx, input int n, input logic with_last);
    cbus_resp_t exp_resp;
    for (int b = 1; b <= n; b++) begin
      exp_resp = mkresp(1'b1, with_last && (b == n), 64'hB000_0000 + 64'(b));
      oresp = exp_resp;
      #1;
      chk("busy_state", 128'(dut.r_state), 128'(1));
      chk("sel_idx", 128'(dut.r_sel_idx), 128'(idx));
      chk("oreq_mirror", 128'(oreq), 128'(ireqs[idx]));
      chk("resp_fwd", 128'(iresps[idx]), 128'(exp_resp));
      chk("resp_other_zero", 128'(iresps[~idx]), 128'(0));
      tick();
    end
    oresp = '0;
  endtask

  initial begin
    reset      = 1'b1;
    ireqs[0]   = '0;
    ireqs[1]   = '0;
    ireqs_f[0] = '0;
    ireqs_f[1] = '0;
    oresp      = '0;
    oresp_f    = '0;
    tick();
    chk("rst_state", 128'(dut.r_state), 128'(0));
    chk("rst_sel", 128'(dut.r_sel_idx), 128'(0));
    chk("rst_rr", 128'(dut.r_rr_ptr), 128'(0));
    chk("rst_oreq", 128'(oreq), 128'(0));
    chk("rst_iresp0", 128'(iresps[0]), 128'(0));
    chk("rst_iresp1", 128'(iresps[1]), 128'(0));
    reset = 1'b0;
    tick();

    // Single requester, 16-beat read on index 1
    ireqs[1] = mkreq(1'b0, 32'h0000_2000, MLEN16, 8'hFF, 64'h0);
    #1;
    chk("idle_oreq_zero", 128'(oreq), 128'(0));
    tick();
    oresp = mkresp(1'b0, 1'b0, 64'h0);
    #1;
    chk("wait_no_ready", 128'(iresps[1]), 128'(0));
    tick();
    run_burst(1'b1, 16, 1'b1);
    ireqs[1].valid = 1'b0;
    #1;
    chk("single_idle", 128'(dut.r_state), 128'(0));
    chk("single_rr", 128'(dut.r_rr_ptr), 128'(0));
    chk("single_oreq_zero", 128'(oreq), 128'(0));
    tick();

    // Round-robin contention: grants 0, 1, 0 with an idle cycle between each
    ireqs[0] = mkreq(1'b0, 32'h0000_3000, MLEN16, 8'hFF, 64'h0);
    ireqs[1] = mkreq(1'b0, 32'h0000_4000, MLEN16, 8'hFF, 64'h0);
    tick();
    chk("rr_grant0_sel", 128'(dut.r_sel_idx), 128'(0));
    run_burst(1'b0, 16, 1'b1);
    chk("rr_gap1_state", 128'(dut.r_state), 128'(0));
    chk("rr_gap1_oreq", 128'(oreq), 128'(0));
    chk("rr_ptr1", 128'(dut.r_rr_ptr), 128'(1));
    tick();
    chk("rr_grant1_sel", 128'(dut.r_sel_idx), 128'(1));
    run_burst(1'b1, 16, 1'b1);
    chk("rr_gap2_state", 128'(dut.r_state), 128'(0));
    chk("rr_ptr2", 128'(dut.r_rr_ptr), 128'(0));
    tick();
    chk("rr_grant2_sel", 128'(dut.r_sel_idx), 128'(0));
    run_burst(1'b0, 16, 1'b1);
    chk("rr_ptr3", 128'(dut.r_rr_ptr), 128'(1));
    ireqs[0].valid = 1'b0;
    ireqs[1].valid = 1'b0;
    tick();

    // Uncached single-beat write on index 1
    ireqs[1] = mkreq(1'b1, 32'h0000_1000, MLEN1, 8'h0F, 64'hDEAD_BEEF_0123_4567);
    tick();
    chk("unc_oreq", 128'(oreq), 128'(mkreq(1'b1, 32'h0000_1000, MLEN1, 8'h0F, 64'hDEAD_BEEF_0123_4567)));
    run_burst(1'b1, 1, 1'b1);
    ireqs[1].valid = 1'b0;
    #1;
    chk("unc_idle", 128'(dut.r_state), 128'(0));
    chk("unc_rr", 128'(dut.r_rr_ptr), 128'(0));
    tick();

    // Abort after 3 beats; pending index 1 wins next
    ireqs[0] = mkreq(1'b0, 32'h0000_5000, MLEN16, 8'hFF, 64'h0);
    ireqs[1] = mkreq(1'b0, 32'h0000_6000, MLEN16, 8'hFF, 64'h0);
    tick();
    run_burst(1'b0, 3, 1'b0);
    ireqs[0].valid = 1'b0;
    #1;
    chk("abort_oreq_valid", 128'(oreq.valid), 128'(0));
    chk("abort_still_busy", 128'(dut.r_state), 128'(1));
    tick();
    chk("abort_idle", 128'(dut.r_state), 128'(0));
    chk("abort_rr", 128'(dut.r_rr_ptr), 128'(0));
    tick();
    chk("abort_next_sel", 128'(dut.r_sel_idx), 128'(1));

    // Reset at beat 5 of index-1 burst
    run_burst(1'b1, 4, 1'b0);
    oresp = mkresp(1'b1, 1'b0, 64'h5);
    reset = 1'b1;
    tick();
    chk("mid_rst_state", 128'(dut.r_state), 128'(0));
    chk("mid_rst_sel", 128'(dut.r_sel_idx), 128'(0));
    chk("mid_rst_rr", 128'(dut.r_rr_ptr), 128'(0));
    chk("mid_rst_oreq_valid", 128'(oreq.valid), 128'(0));
    chk("mid_rst_iresp1", 128'(iresps[1]), 128'(0));
    reset = 1'b0;
    ireqs[1].valid = 1'b0;
    oresp = mkresp(1'b1, 1'b1, 64'h77);
    #1;
    chk("stray_iresp0", 128'(iresps[0]), 128'(0));
    chk("stray_iresp1", 128'(iresps[1]), 128'(0));
    tick();
    chk("stray_state", 128'(dut.r_state), 128'(0));
    chk("stray_rr", 128'(dut.r_rr_ptr), 128'(0));
    oresp = '0;

    // Fixed priority: index 0 always wins, index 1 starves
    ireqs_f[0] = mkreq(1'b0, 32'h0000_7000, MLEN16, 8'hFF, 64'h0);
    ireqs_f[1] = mkreq(1'b0, 32'h0000_8000, MLEN16, 8'hFF, 64'h0);
    #1;
    chk("fp_idle_oreq", 128'(oreq_f), 128'(0));
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("fp_sel", 128'(dut_fp.r_sel_idx), 128'(0));
      for (int b = 0; b < 2; b++) begin
        oresp_f = mkresp(1'b1, b == 1, 64'hF000 + 64'(b));
        #1;
        chk("fp_fwd0", 128'(iresps_f[0]), 128'(mkresp(1'b1, b == 1, 64'hF000 + 64'(b))));
        chk("fp_starve1", 128'(iresps_f[1].ready), 128'(0));
        tick();
      end
      oresp_f = '0;
      #1;
      chk("fp_gap_state", 128'(dut_fp.r_state), 128'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 Parameter NUM_INPUTS, default 2, number of cbus requesters (index 0 = ICache, 1 = DCache in the standard build).
REQ-002 Parameter ROUND_ROBIN, default 1, 1 = rotating priority, 0 = fixed priority with lowest index winning.
REQ-003 clk  input  1  sole clock, all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 ireqs  input  cbus_req_t[NUM_INPUTS]  requests from the caches.
REQ-006 iresps  output  cbus_resp_t[NUM_INPUTS]  per-requester responses.
REQ-007 oreq  output  cbus_req_t  request to the shared memory bus.
REQ-008 oresp  input  cbus_resp_t  response from the memory bus (ready, last, data).

Function
REQ-009 The arbiter SHALL have two states: IDLE and BUSY, plus registers sel_idx (clog2(NUM_INPUTS) bits, min 1) and rr_ptr (same width).
REQ-010 In IDLE, oreq SHALL be all-zero and every iresps[i] SHALL be all-zero.
REQ-011 In IDLE with at least one ireqs[i].valid, the arbiter SHALL latch the winner into sel_idx and enter BUSY on the next edge; grant latency = 1 cycle.
REQ-012 Winner selection with ROUND_ROBIN=1: first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_INPUTS.
REQ-013 Winner selection with ROUND_ROBIN=0: lowest valid index.
REQ-014 In BUSY, oreq SHALL equal ireqs[sel_idx] bit-for-bit (valid, is_write, size, addr, strobe, data, len, burst).
REQ-015 In BUSY, iresps[sel_idx] SHALL equal oresp; every other iresps[j] SHALL be all-zero (ready=0, last=0, data=0).
REQ-016 The grant SHALL be held for the whole burst; non-selected requests SHALL be ignored and not dropped, since they keep valid asserted.
REQ-017 BUSY -> IDLE SHALL occur on the edge where oresp.ready && oresp.last.
REQ-018 On that edge, rr_ptr SHALL become (sel_idx+1) mod NUM_INPUTS; rr_ptr is unchanged otherwise.
REQ-019 If ireqs[sel_idx].valid is 0 in BUSY (requester abort), oreq.valid SHALL be 0 that cycle, and the FSM SHALL return to IDLE on the next edge without updating rr_ptr.
REQ-020 After a burst ends, the arbiter SHALL spend at least one cycle in IDLE before the next grant; no back-to-back grant in the same cycle as last.
REQ-021 A requester that raises valid in the same cycle another burst completes SHALL be considered in the following IDLE cycle under the updated rr_ptr.
REQ-022 oresp.ready/last arriving while in IDLE SHALL be ignored and SHALL NOT alter state.
REQ-023 The arbiter SHALL contain no combinational path from oresp to oreq.
REQ-024 sel_idx SHALL never exceed NUM_INPUTS-1.

Reset
REQ-025 With reset=1 at a posedge, state SHALL become IDLE, sel_idx=0, rr_ptr=0.
REQ-026 During and after reset, oreq SHALL be all-zero and all iresps zero until a grant.
REQ-027 Reset asserted mid-burst SHALL abandon the burst immediately: oreq.valid=0 the cycle after the reset edge, with no further ready/last forwarded.

Verification
REQ-028 Single requester: ireqs[1] valid, len=MLEN16 read; memory returns 16 ready beats, last on beat 16 -> oreq mirrors ireqs[1] from cycle 1; iresps[1] gets 16 beats; IDLE after last; rr_ptr=0.
REQ-029 Contention, RR: both valid from reset, ROUND_ROBIN=1 -> grants go 0, then 1, then 0; each full burst completes; each grant is separated by one IDLE cycle.
REQ-030 Contention, fixed: ROUND_ROBIN=0, both continuously valid -> index 0 is always granted and index 1 is starved; iresps[1].ready stays 0 throughout.
REQ-031 Uncached single beat: ireqs[1] with len=MLEN1, write, strobe=8'h0F, addr=0x0000_1000 -> oreq carries identical fields; one ready+last beat; IDLE next cycle.
REQ-032 Abort: ireqs[0] drops valid after 3 of 16 beats -> oreq.valid=0 that cycle; IDLE next cycle; pending ireqs[1] granted next; rr_ptr unchanged at 0.
REQ-033 Reset mid-burst: reset pulsed at beat 5 of ireqs[1] burst -> IDLE, sel_idx=0, rr_ptr=0, all outputs zero; stray oresp.ready afterwards is ignored.
